// File: rtl/uart_pkg.sv
// uart_pkg: shared UART width macro, FSM state encodings and line idle level
`ifndef UART_PKG_CLOG2
`define UART_PKG_CLOG2
`define CLOG2(x) $clog2(x)
`endif

package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: reloading down-counter that flags the last clock of each bit period
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIVISOR = 104
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_done
);
  localparam int W = (`CLOG2(DIVISOR) < 1) ? 1 : `CLOG2(DIVISOR);
  localparam logic [W-1:0] TOP = W'(DIVISOR - 1);
  logic [W-1:0] cnt;
  assign bit_done = cnt == '0;
  // Free-running reload keeps consecutive bits exactly DIVISOR clocks long
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (restart || bit_done) ? TOP : cnt - W'(1);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops the byte FIFO and shifts each byte out as a UART frame on serial
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DIVISOR = 104,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_available,
  input  logic [WIDTH-1:0] read_data,
  output logic             read_strobe,
  output logic             serial,
  output logic             busy
);
  state_t state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [2:0] idx, idx_n;
  logic bit_done, load, serial_n, par_bit;
  baud_tick_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk(clk),
    .reset_n(reset_n),
    .restart(state == IDLE && data_available),
    .bit_done(bit_done)
  );
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) par_bit <= 1'b0;
    else if (load) par_bit <= ^read_data;
`else
  assign par_bit = UART_IDLE_LEVEL;
`endif
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    load    = 1'b0;
    case (state)
      IDLE:  if (data_available) begin
        state_n = START;
        load    = 1'b1;
      end
      START: if (bit_done) begin
        state_n = DATA;
        idx_n   = 3'd0;
      end
      DATA:  if (bit_done) begin
        shift_n = shift >> 1;
        idx_n   = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (idx == 3'(WIDTH - 1)) state_n = PARITY;
`else
        if (idx == 3'(WIDTH - 1)) state_n = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) state_n = STOP;
`endif
      STOP:  if (bit_done) begin
        state_n = data_available ? START : IDLE;
        load    = data_available;
      end
      default: state_n = IDLE;
    endcase
    if (load) shift_n = read_data;
    serial_n = state_n == START  ? 1'b0 :
               state_n == DATA   ? shift_n[0] :
               state_n == PARITY ? par_bit : UART_IDLE_LEVEL;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      shift       <= '0;
      idx         <= '0;
      serial      <= UART_IDLE_LEVEL;
      busy        <= 1'b0;
      read_strobe <= 1'b0;
    end else begin
      state       <= state_n;
      shift       <= shift_n;
      idx         <= idx_n;
      serial      <= serial_n;
      busy        <= state_n != IDLE;
      read_strobe <= load;
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboarded FIFO-to-UART bench with a queue-backed FIFO model
module tb_fifo_uart_tx;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * D;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic data_available = 1'b0;
  logic [7:0] read_data = 8'h00;
  logic read_strobe, serial, busy;

  int errors = 0, checks = 0, cyc = 0, strobes = 0, bad_strobe = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int strobe_cyc[$];

  fifo_uart_tx #(.DIVISOR(D), .WIDTH(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_available(data_available),
    .read_data(read_data),
    .read_strobe(read_strobe),
    .serial(serial),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    data_available = fifo_q.size() != 0;
    read_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // every wait goes through here so the FIFO model lives in one process
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (read_strobe === 1'b1) begin
      strobes++;
      strobe_cyc.push_back(cyc);
      if (fifo_q.size() == 0) bad_strobe++;
      else void'(fifo_q.pop_front());
    end
    refresh();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    refresh();
  endtask

  task automatic rx_frame(input string name);
    logic [FL-1:0] got, want, bz;
    logic [FB-1:0] f;
    logic [7:0] b;
    tick();
    checks++;
    if (serial !== 1'b0) begin
      errors++;
      $display("FAIL %s start latency: serial=%b required 0", name, serial);
      return;
    end
    got = '0;
    bz = '0;
    got[0] = serial;
    bz[0] = busy;
    for (int i = 1; i < FL; i++) begin
      tick();
      got[i] = serial;
      bz[i] = busy;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: frame seen with no byte expected", name);
      return;
    end
    b = exp_q.pop_front();
    f = '0;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    f[FB-1] = 1'b1;
    for (int i = 0; i < FL; i++) want[i] = f[i/D];
    if (got !== want) begin
      errors++;
      $display("FAIL %s line byte %h: got %b required %b", name, b, got, want);
    end
    checks++;
    if (bz !== '1) begin
      errors++;
      $display("FAIL %s busy: got %b required all ones", name, bz);
    end
  endtask

  task automatic test_reset();
    logic bad = 1'b0;
    push(8'h77);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (serial !== 1'b1 || busy !== 1'b0 || read_strobe !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || strobes != 0) begin
      errors++;
      $display("FAIL reset hold: bad=%b strobes=%0d required 0/0", bad, strobes);
    end
    fifo_q.delete();
    exp_q.delete();
    refresh();
    reset_n = 1'b1;
  endtask

  task automatic test_empty();
    logic bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (serial !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || strobes != 0) begin
      errors++;
      $display("FAIL empty idle: bad=%b strobes=%0d required 0/0", bad, strobes);
    end
  endtask

  task automatic test_single();
    int s0 = strobes;
    push(8'hA5);
    rx_frame("single");
    tick();
    checks++;
    if (strobes - s0 != 1) begin
      errors++;
      $display("FAIL single strobes: got %0d required 1", strobes - s0);
    end
    checks++;
    if (serial !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single idle after: serial=%b busy=%b required 1/0", serial, busy);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = strobes;
    push(8'h00);
    push(8'hFF);
    rx_frame("b2b first");
    rx_frame("b2b second");
    tick();
    checks++;
    if (strobes - s0 != 2) begin
      errors++;
      $display("FAIL b2b strobes: got %0d required 2", strobes - s0);
    end else begin
      checks++;
      if (strobe_cyc[strobe_cyc.size()-1] - strobe_cyc[strobe_cyc.size()-2] != FL) begin
        errors++;
        $display("FAIL b2b strobe spacing: got %0d required %0d",
                 strobe_cyc[strobe_cyc.size()-1] - strobe_cyc[strobe_cyc.size()-2], FL);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle after: busy=%b required 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    int s0;
    push(8'h5A);
    tick();
    checks++;
    if (serial !== 1'b0) begin
      errors++;
      $display("FAIL midreset start: serial=%b required 0", serial);
    end
    for (int i = 0; i < 17; i++) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (serial !== 1'b1 || busy !== 1'b0 || read_strobe !== 1'b0) begin
      errors++;
      $display("FAIL midreset async: serial=%b busy=%b strobe=%b required 1/0/0",
               serial, busy, read_strobe);
    end
    exp_q.delete();
    s0 = strobes;
    push(8'h3C);
    tick();
    tick();
    reset_n = 1'b1;
    rx_frame("after reset");
    tick();
    checks++;
    if (strobes - s0 != 1) begin
      errors++;
      $display("FAIL midreset strobes: got %0d required 1", strobes - s0);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    push(8'h01);
    push(8'h03);
    rx_frame("parity first");
    rx_frame("parity second");
    tick();
  endtask
`endif

  initial begin
    refresh();
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_mid_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    for (int i = 0; i < 3 * FL; i++) tick();
    checks++;
    if (bad_strobe != 0 || exp_q.size() != 0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL final: empty-strobes=%0d pending-exp=%0d fifo=%0d required 0/0/0",
               bad_strobe, exp_q.size(), fifo_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
